// File: rtl/sweep_timer_bank_pkg.sv
// Shared types and constants for the sweep timer bank.
// Build option: SWEEP_TIMER_READBACK_EN enables staged-value readback.
package sweep_timer_pkg;

  localparam int DEF_CH = 4;
  localparam int DEF_W  = 48;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic wr;
    logic commit;
    logic start;
    logic stop;
    logic cont;
  } ch_ctl_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic pend;
  } ch_sts_t;

  function automatic int aw_of(int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/sweep_timer_bank_if.sv
// Control/status bundle between the control regs and the sweep timer bank.
// Build option: SWEEP_TIMER_READBACK_EN adds i_rd_ch / o_rd_data.
interface sweep_timer_bank_if
  import sweep_timer_pkg::*;
#(
  parameter int CH = DEF_CH,
  parameter int W  = DEF_W
) ();

  localparam int AW = aw_of(CH);

  logic            i_wr_en;
  logic [AW-1:0]   i_wr_ch;
  logic [W-1:0]    i_wr_data;
  logic            i_commit;
  logic [CH-1:0]   i_start;
  logic [CH-1:0]   i_stop;
  logic [CH-1:0]   i_continuous;
  logic [CH*W-1:0] o_time_value;
  logic [CH*W-1:0] o_count;
  logic [CH-1:0]   o_busy;
  logic [CH-1:0]   o_done;
  logic            o_pending;

`ifdef SWEEP_TIMER_READBACK_EN
  logic [AW-1:0]   i_rd_ch;
  logic [W-1:0]    o_rd_data;

  modport master (
    output i_wr_en, i_wr_ch, i_wr_data, i_commit,
    output i_start, i_stop, i_continuous, i_rd_ch,
    input  o_time_value, o_count, o_busy, o_done,
    input  o_pending, o_rd_data
  );

  modport slave (
    input  i_wr_en, i_wr_ch, i_wr_data, i_commit,
    input  i_start, i_stop, i_continuous, i_rd_ch,
    output o_time_value, o_count, o_busy, o_done,
    output o_pending, o_rd_data
  );
`else
  modport master (
    output i_wr_en, i_wr_ch, i_wr_data, i_commit,
    output i_start, i_stop, i_continuous,
    input  o_time_value, o_count, o_busy, o_done,
    input  o_pending
  );

  modport slave (
    input  i_wr_en, i_wr_ch, i_wr_data, i_commit,
    input  i_start, i_stop, i_continuous,
    output o_time_value, o_count, o_busy, o_done,
    output o_pending
  );
`endif

endinterface

// File: rtl/sweep_timer_bank_channel.sv
// One sweep channel: staged/active pair, pending-commit flag, IDLE/RUN FSM, counter.
// Build option: SWEEP_TIMER_READBACK_EN exposes the staged register.
module sweep_timer_channel
  import sweep_timer_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  ch_ctl_t      i_ctl,
  input  logic [W-1:0] i_wr_data,
`ifdef SWEEP_TIMER_READBACK_EN
  output logic [W-1:0] o_staged,
`endif
  output logic [W-1:0] o_active,
  output logic [W-1:0] o_count,
  output ch_sts_t      o_sts
);

  state_e       r_state;
  logic [W-1:0] r_staged;
  logic [W-1:0] r_active;
  logic [W-1:0] r_count;
  logic         r_busy;
  logic         r_done;
  logic         r_pend;

  logic         w_pend;
  logic         w_term;
  logic         w_go;
  logic [W-1:0] w_next_act;

  // Transfers always take the staged value as it stood before this edge.
  assign w_pend     = r_pend | i_ctl.commit;
  assign w_next_act = w_pend ? r_staged : r_active;
  assign w_term     = (r_count == r_active - W'(1));
  assign w_go       = i_ctl.start & ~i_ctl.stop
                    & (r_active != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_staged <= '0;
      r_active <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_ctl.wr) r_staged <= i_wr_data;
      unique case (r_state)
        ST_IDLE: begin
          r_active <= w_next_act;
          r_pend   <= 1'b0;
          if (w_go) begin
            r_state <= ST_RUN;
            r_count <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_ctl.stop) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_active <= w_next_act;
            r_pend   <= 1'b0;
          end else if (w_term) begin
            r_done   <= 1'b1;
            r_count  <= '0;
            r_active <= w_next_act;
            r_pend   <= 1'b0;
            if (!(i_ctl.cont && w_next_act != '0)) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_count <= r_count + W'(1);
            r_pend  <= w_pend;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SWEEP_TIMER_READBACK_EN
  assign o_staged = r_staged;
`endif
  assign o_active = r_active;
  assign o_count  = r_count;
  assign o_sts    = '{busy: r_busy, done: r_done, pend: r_pend};

endmodule

// File: rtl/sweep_timer_bank.sv
// CH-channel double-buffered sweep timer bank feeding the sweep/DDS core.
// Build option: SWEEP_TIMER_READBACK_EN adds a registered staged readback mux.
module sweep_timer_bank
  import sweep_timer_pkg::*;
#(
  parameter int CH = DEF_CH,
  parameter int W  = DEF_W
) (
  input logic               i_clk,
  input logic               i_rst,
  sweep_timer_bank_if.slave bus
);

  localparam int AW = aw_of(CH);

  logic [CH-1:0] w_pend;
`ifdef SWEEP_TIMER_READBACK_EN
  logic [W-1:0]  w_staged [CH];
`endif

  for (genvar g = 0; g < CH; g++) begin : g_ch
    ch_ctl_t      w_ctl;
    ch_sts_t      w_sts;
    logic [W-1:0] w_act;
    logic [W-1:0] w_cnt;

    // Out-of-range channel indices decode to no channel at all.
    assign w_ctl.wr     = bus.i_wr_en & (bus.i_wr_ch == AW'(g));
    assign w_ctl.commit = bus.i_commit;
    assign w_ctl.start  = bus.i_start[g];
    assign w_ctl.stop   = bus.i_stop[g];
    assign w_ctl.cont   = bus.i_continuous[g];

    sweep_timer_channel #(.W(W)) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_ctl     (w_ctl),
      .i_wr_data (bus.i_wr_data),
`ifdef SWEEP_TIMER_READBACK_EN
      .o_staged  (w_staged[g]),
`endif
      .o_active  (w_act),
      .o_count   (w_cnt),
      .o_sts     (w_sts)
    );

    assign bus.o_time_value[g*W +: W] = w_act;
    assign bus.o_count[g*W +: W]      = w_cnt;
    assign bus.o_busy[g]              = w_sts.busy;
    assign bus.o_done[g]              = w_sts.done;
    assign w_pend[g]                  = w_sts.pend;
  end

  assign bus.o_pending = |w_pend;

`ifdef SWEEP_TIMER_READBACK_EN
  logic [W-1:0] w_rd_sel;
  logic [W-1:0] r_rd_data;

  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < CH; i++) begin
      if (bus.i_rd_ch == AW'(i)) w_rd_sel = w_staged[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rd_data <= '0;
    else       r_rd_data <= w_rd_sel;
  end

  assign bus.o_rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_sweep_timer_bank.sv
// Bench for sweep_timer_bank: directed scenarios plus random traffic,
// checked every cycle against a sweep-start-time reference model.
module tb_sweep_timer_bank;
  import sweep_timer_pkg::*;

  localparam int CH = 3;
  localparam int W  = 12;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sweep_timer_bank_if #(.CH(CH), .W(W)) bus ();

  sweep_timer_bank #(.CH(CH), .W(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a running channel is described by the edge at which
  // its current sweep began; count is simply edges elapsed since then.
  logic [W-1:0] m_stg [CH];
  logic [W-1:0] m_act [CH];
  bit           m_run [CH];
  bit           m_pend[CH];
  bit           m_done[CH];
  longint       m_t0  [CH];
  logic [W-1:0] m_rd;
  longint       n = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad < 40)
        $display("FAIL %s @edge %0d: got %0h want %0h", nm, n, act, exp);
    end
  endtask

  task automatic model_step();
    bit           pn;
    logic [W-1:0] ao;
    n++;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_stg[i] = '0; m_act[i] = '0; m_run[i] = 0;
        m_pend[i] = 0; m_done[i] = 0; m_t0[i] = 0;
      end
      m_rd = '0;
      return;
    end
`ifdef SWEEP_TIMER_READBACK_EN
    begin
      int r;
      r = int'(bus.i_rd_ch);
      m_rd = (r < CH) ? m_stg[r] : '0;
    end
`endif
    for (int i = 0; i < CH; i++) begin
      pn = m_pend[i] || bus.i_commit;
      m_done[i] = 0;
      if (!m_run[i]) begin
        ao = m_act[i];
        if (pn) m_act[i] = m_stg[i];
        m_pend[i] = 0;
        if (bus.i_start[i] && !bus.i_stop[i] && ao != 0) begin
          m_run[i] = 1;
          m_t0[i]  = n;
        end
      end else if (bus.i_stop[i]) begin
        m_run[i] = 0;
        if (pn) m_act[i] = m_stg[i];
        m_pend[i] = 0;
      end else if (n - m_t0[i] == longint'(m_act[i])) begin
        m_done[i] = 1;
        if (pn) m_act[i] = m_stg[i];
        m_pend[i] = 0;
        m_t0[i]   = n;
        m_run[i]  = bus.i_continuous[i] && m_act[i] != 0;
      end else begin
        m_pend[i] = pn;
      end
      if (bus.i_wr_en && int'(bus.i_wr_ch) == i) m_stg[i] = bus.i_wr_data;
    end
  endtask

  task automatic compare_all();
    logic [CH*W-1:0] et, ec;
    logic [CH-1:0]   eb, ed;
    bit              ep;
    et = '0; ec = '0; eb = '0; ed = '0; ep = 0;
    for (int i = 0; i < CH; i++) begin
      et[i*W +: W] = m_act[i];
      ec[i*W +: W] = m_run[i] ? W'(n - m_t0[i]) : '0;
      eb[i] = m_run[i];
      ed[i] = m_done[i];
      ep = ep | m_pend[i];
    end
    check("time_value", 64'(bus.o_time_value), 64'(et));
    check("count", 64'(bus.o_count), 64'(ec));
    check("busy", 64'(bus.o_busy), 64'(eb));
    check("done", 64'(bus.o_done), 64'(ed));
    check("pending", 64'(bus.o_pending), 64'(ep));
`ifdef SWEEP_TIMER_READBACK_EN
    check("rd_data", 64'(bus.o_rd_data), 64'(m_rd));
`endif
  endtask

  initial forever begin
    @(negedge clk);
    if (n > 0) compare_all();
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.i_wr_en   = 1'b0;
    bus.i_wr_ch   = '0;
    bus.i_wr_data = '0;
    bus.i_commit  = 1'b0;
    bus.i_start   = '0;
    bus.i_stop    = '0;
  endtask

  task automatic wr(int ch, int v);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_ch   = AW'(ch);
    bus.i_wr_data = W'(v);
    cyc();
    idle_in();
  endtask

  task automatic commit_();
    bus.i_commit = 1'b1;
    cyc();
    idle_in();
  endtask

  task automatic start_(int ch);
    bus.i_start[ch] = 1'b1;
    cyc();
    idle_in();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_continuous = '0;
    cyc();
    rst = 1'b0;
    idle_in();
  endtask

  function automatic logic [W-1:0] cnt_of(int ch);
    logic [CH*W-1:0] v;
    v = bus.o_count;
    return v[ch*W +: W];
  endfunction

  function automatic logic [W-1:0] tv_of(int ch);
    logic [CH*W-1:0] v;
    v = bus.o_time_value;
    return v[ch*W +: W];
  endfunction

  initial begin
    idle_in();
    bus.i_continuous = '0;
`ifdef SWEEP_TIMER_READBACK_EN
    bus.i_rd_ch = '0;
`endif
    // T1: reset dominates random inputs
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.i_wr_en      = 1'($urandom);
      bus.i_wr_ch      = AW'($urandom);
      bus.i_wr_data    = W'($urandom);
      bus.i_commit     = 1'($urandom);
      bus.i_start      = CH'($urandom);
      bus.i_stop       = '0;
      bus.i_continuous = CH'($urandom);
      cyc();
    end
    check("t1_tv", 64'(bus.o_time_value), 64'd0);
    check("t1_count", 64'(bus.o_count), 64'd0);
    check("t1_busy", 64'(bus.o_busy), 64'd0);
    check("t1_done", 64'(bus.o_done), 64'd0);
    check("t1_pend", 64'(bus.o_pending), 64'd0);
    rst = 1'b0;
    idle_in();
    bus.i_continuous = '0;
    wr(0, 6);
    commit_();
    start_(0);
    cyc();
    cyc();
    check("t1_run_count", 64'(cnt_of(0)), 64'd2);
    check("t1_run_busy", 64'(bus.o_busy[0]), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t1_rst_busy", 64'(bus.o_busy), 64'd0);
    check("t1_rst_count", 64'(bus.o_count), 64'd0);

    // T2: one-shot period 3 on ch1
    do_reset();
    wr(1, 3);
    commit_();
    start_(1);
    check("t2_c0", 64'(cnt_of(1)), 64'd0);
    cyc();
    check("t2_c1", 64'(cnt_of(1)), 64'd1);
    cyc();
    check("t2_c2", 64'(cnt_of(1)), 64'd2);
    check("t2_nodone", 64'(bus.o_done), 64'd0);
    cyc();
    check("t2_done", 64'(bus.o_done), 64'b010);
    check("t2_idle", 64'(bus.o_busy), 64'd0);
    cyc();
    check("t2_done_1cyc", 64'(bus.o_done), 64'd0);

    // T3: continuous with deferred commit
    do_reset();
    wr(0, 5);
    commit_();
    bus.i_continuous = 3'b001;
    start_(0);
    cyc();
    check("t3_c1", 64'(cnt_of(0)), 64'd1);
    bus.i_wr_en = 1'b1; bus.i_wr_ch = 2'd0; bus.i_wr_data = 12'd2;
    bus.i_commit = 1'b1;
    cyc();
    idle_in();
    check("t3_pend", 64'(bus.o_pending), 64'd1);
    check("t3_tv_held", 64'(tv_of(0)), 64'd5);
    cyc();
    cyc();
    check("t3_c4", 64'(cnt_of(0)), 64'd4);
    cyc();
    check("t3_done", 64'(bus.o_done[0]), 64'd1);
    check("t3_tv_new", 64'(tv_of(0)), 64'd2);
    check("t3_pend_clr", 64'(bus.o_pending), 64'd0);
    check("t3_still_busy", 64'(bus.o_busy[0]), 64'd1);
    cyc();
    cyc();
    check("t3_period2", 64'(bus.o_done[0]), 64'd1);
    bus.i_continuous = '0;

    // T4: edge cases
    do_reset();
    start_(0);
    check("t4_zero_busy", 64'(bus.o_busy), 64'd0);
    cyc();
    check("t4_zero_done", 64'(bus.o_done), 64'd0);
    wr(0, 4);
    commit_();
    bus.i_start[0] = 1'b1; bus.i_stop[0] = 1'b1;
    cyc();
    idle_in();
    check("t4_stop_beats_start", 64'(bus.o_busy), 64'd0);
    wr(3, 7);
    commit_();
    check("t4_bad_ch", 64'(bus.o_time_value), 64'h000_000_004);
    start_(0);
    cyc();
    cyc();
    start_(0);
    check("t4_no_retrig", 64'(cnt_of(0)), 64'd3);
    bus.i_stop[0] = 1'b1;
    cyc();
    idle_in();
    check("t4_stop_beats_term", 64'(bus.o_done), 64'd0);
    check("t4_stop_idle", 64'(bus.o_busy), 64'd0);

    // T5: maximum period, then period 1 continuous
    do_reset();
    wr(2, 4095);
    commit_();
    start_(2);
    for (int k = 0; k < 4094; k++) cyc();
    check("t5_top_count", 64'(cnt_of(2)), 64'd4094);
    check("t5_top_nodone", 64'(bus.o_done), 64'd0);
    cyc();
    check("t5_top_done", 64'(bus.o_done), 64'b100);
    check("t5_top_wrap", 64'(cnt_of(2)), 64'd0);
    check("t5_top_idle", 64'(bus.o_busy), 64'd0);
    wr(1, 1);
    commit_();
    bus.i_continuous = 3'b010;
    start_(1);
    check("t5_p1_nodone", 64'(bus.o_done), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("t5_p1_done", 64'(bus.o_done), 64'b010);
    end

`ifdef SWEEP_TIMER_READBACK_EN
    // T6: staged readback
    do_reset();
    wr(2, 'hBCD);
    bus.i_rd_ch = 2'd2;
    cyc();
    check("t6_rd", 64'(bus.o_rd_data), 64'hBCD);
    bus.i_rd_ch = 2'd3;
    cyc();
    check("t6_rd_oob", 64'(bus.o_rd_data), 64'd0);
`endif

    // Random traffic, checked only by the per-cycle model compare
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      idle_in();
      if (k % 64 == 0) bus.i_continuous = CH'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      bus.i_wr_en   = ($urandom_range(0, 9) < 3);
      bus.i_wr_ch   = AW'($urandom);
      bus.i_wr_data = W'($urandom_range(0, 9));
      bus.i_commit  = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < CH; i++) begin
        bus.i_start[i] = ($urandom_range(0, 4) == 0);
        bus.i_stop[i]  = ($urandom_range(0, 19) == 0);
      end
      if (bus.i_commit) bus.i_start = '0;
`ifdef SWEEP_TIMER_READBACK_EN
      bus.i_rd_ch = AW'($urandom);
`endif
      cyc();
    end
    rst = 1'b0;
    idle_in();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
